prbs4_checker: RTL
==================

# prbs4_checker

Serial receiver-side checker for the 4-bit maximal-length LFSR stream (polynomial x^4+x+1, period 15, canonical sequence 000100110101111 from seed 4'b0001, serial bit = state bit 3). It self-synchronises to the incoming bitstream, declares lock after a run of correct predictions, and counts bit errors while locked. It sits at the far end of the link from the LFSR generator, on the same clock, for link bring-up and BER tests.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive correct predictions required in VERIFY to declare lock (1..255)
- UNLOCK_ERRS, 4: consecutive mismatches in LOCKED that drop lock (1..15)
- CNT_W, 16: width of err_cnt and bit_cnt

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  1  received serial bit
- din_valid  in  1  din is sampled on this edge when high; otherwise the block holds state
- err_clr  in  1  synchronous clear of err_cnt (and bit_cnt)
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per detected mismatch while LOCKED
- err_cnt  out  CNT_W  saturating mismatch count
- bit_cnt  out  CNT_W  saturating count of valid bits checked while LOCKED (see Configuration)

## Operation
- History register h[3:0], h[0] = newest accepted bit. Prediction p = h[2] ^ h[3] (b[n] = b[n-3] ^ b[n-4]).
- Every accepted bit (din_valid=1) shifts into h in all states: the checker is self-synchronising; the received bit, not the prediction, is stored.
- States:
  - SEARCH: fill counter counts 0..3; on the 4th accepted bit -> VERIFY, match_cnt=0. No comparison.
  - VERIFY: compare din vs p. Match and h != 0 -> match_cnt+1; when match_cnt reaches LOCK_CNT -> LOCKED. Mismatch, or h == 4'b0000 (lock-up pattern) -> match_cnt=0, stay.
  - LOCKED: match -> consec_err=0. Mismatch -> err_pulse=1, err_cnt+1 (saturate at all-ones), consec_err+1; when consec_err reaches UNLOCK_ERRS -> SEARCH, fill counter=0, consec_err=0, locked drops.
- A single flipped line bit while LOCKED produces exactly 3 mismatches (at bits n, n+3, n+4); max run of 2 consecutive, so it never unlocks with UNLOCK_ERRS >= 3.
- err_clr: err_cnt (and bit_cnt) <= 0; clear wins over a simultaneous increment; err_pulse still fires; state unaffected.
- err_cnt holds its value through SEARCH/VERIFY and loss of lock.

## Timing
- Reset values: state SEARCH, h=0, all counters 0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0. Reset asserted mid-operation takes effect immediately, asynchronously.
- All outputs registered; err_pulse and err_cnt update on the same edge that accepts the offending bit (visible the following cycle).
- With continuous din_valid from reset release: bits 1-4 fill, bits 5..(4+LOCK_CNT) verify; locked rises on the edge accepting bit 4+LOCK_CNT (bit 12 at default).
- din_valid low: no shift, no compare, counters hold, err_pulse=0.

## Configuration
- PRBS_CHK_BITCNT_EN defined: bit_cnt increments (saturating) on each accepted bit while LOCKED, cleared by err_clr, giving a BER denominator.
- Not defined: bit_cnt counter is not built; port remains and is tied to 0.

## Test plan
- Reset release, continuous valid stream 000100110101111 repeated -> locked rises on the 12th bit edge, err_cnt stays 0 for 100 bits.
- Locked, flip one bit -> exactly 3 err_pulse cycles (bits n, n+3, n+4), err_cnt=3, locked stays 1.
- Locked, drive din=constant inverted stream for 4 bits -> locked drops on the 4th mismatch edge, err_cnt=4, relock after 4+8 further good bits.
- All-zero input for 30 bits after reset -> locked never asserts; err_cnt=0.
- din_valid toggled 1/0 every cycle with good stream -> lock on the 12th valid bit, not the 12th cycle; err_cnt=0.
- err_clr coincident with an error, and rst asserted mid-LOCKED -> err_cnt=0 after clear; rst forces locked=0, err_cnt=0 without a clock edge; with PRBS_CHK_BITCNT_EN, bit_cnt=100 after 100 locked good bits.

Source files
------------

// File: rtl/prbs4_checker.sv
// Receiver-side PRBS4 (x^4+x+1) checker: self-syncs, locks, counts errors.
// Ports: clk, rst (async high), din, din_valid, err_clr -> locked, err_pulse, err_cnt, bit_cnt.
// Option: PRBS_CHK_BITCNT_EN builds bit_cnt (locked valid bits); else bit_cnt tied to 0.
module prbs4_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);
  localparam logic [3:0] UNLK_V = 4'(UNLOCK_ERRS);

  state_t           state, state_n;
  logic [3:0]       h, h_n;
  logic [1:0]       fill, fill_n;
  logic [7:0]       mcnt, mcnt_n;
  logic [3:0]       cerr, cerr_n;
  logic [CNT_W-1:0] err_n;
  logic             pulse_n;
  logic             hit;

  // Next bit of the sequence is b[n-3] ^ b[n-4].
  assign hit = (din == (h[2] ^ h[3]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      h         <= '0;
      fill      <= '0;
      mcnt      <= '0;
      cerr      <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill      <= fill_n;
      mcnt      <= mcnt_n;
      cerr      <= cerr_n;
      err_cnt   <= err_n;
      err_pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    h_n     = h;
    fill_n  = fill;
    mcnt_n  = mcnt;
    cerr_n  = cerr;
    err_n   = err_cnt;
    pulse_n = 1'b0;
    if (din_valid) begin
      // Store the received bit, not the prediction, so we re-sync.
      h_n = {h[2:0], din};
      unique case (state)
        SEARCH: begin
          fill_n = fill + 2'd1;
          if (fill == 2'd3) begin
            state_n = VERIFY;
            mcnt_n  = '0;
          end
        end
        VERIFY: begin
          // All-zero history is the LFSR lock-up state; never trust it.
          if (hit && (h != 4'b0000)) begin
            mcnt_n = mcnt + 8'd1;
            if (mcnt_n == LOCK_V) state_n = LOCKED;
          end else begin
            mcnt_n = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            cerr_n = '0;
          end else begin
            pulse_n = 1'b1;
            if (err_cnt != '1) err_n = err_cnt + 1'b1;
            cerr_n = cerr + 4'd1;
            if (cerr_n == UNLK_V) begin
              state_n = SEARCH;
              fill_n  = '0;
              cerr_n  = '0;
            end
          end
        end
        default: begin
          state_n = SEARCH;
          fill_n  = '0;
        end
      endcase
    end
    if (err_clr) err_n = '0;
  end

  assign locked = (state == LOCKED);

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
    end else if (err_clr) begin
      bits_q <= '0;
    end else if (din_valid && (state == LOCKED) && (bits_q != '1)) begin
      bits_q <= bits_q + 1'b1;
    end
  end

  assign bit_cnt = bits_q;
`else
  assign bit_cnt = '0;
`endif

endmodule
